// File: rtl/fault_sched_pkg.sv
// Shared definitions for the fault mission scheduler.
//   - unit encoding (NONE/EU/CU/RU), which is also the fault_location output code
//   - scheduler state encoding
//   - constant waypoint ROM and block-site table, as functions
//   - default home node
package fault_sched_pkg;

  localparam logic [1:0] UNIT_NONE = 2'd0;
  localparam logic [1:0] UNIT_EU   = 2'd1;
  localparam logic [1:0] UNIT_CU   = 2'd2;
  localparam logic [1:0] UNIT_RU   = 2'd3;

  localparam logic [4:0] HOME_NODE_DEF = 5'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_WAIT_BLK,
    S_GO_BLK,
    S_RECTIFY,
    S_HOME,
    S_DONE
  } state_t;

  // Number of waypoints in a unit's scan/rectify list.
  function automatic logic [2:0] wp_count(input logic [1:0] u);
    case (u)
      UNIT_EU, UNIT_CU: return 3'd3;
      UNIT_RU:          return 3'd4;
      default:          return 3'd0;
    endcase
  endfunction

  // Waypoint idx of unit u. Indices past the end of a list repeat its last node.
  function automatic logic [4:0] wp_node(input logic [1:0] u, input logic [1:0] idx);
    logic [4:0] node;
    node = HOME_NODE_DEF;
    case (u)
      UNIT_EU:
        case (idx)
          2'd0:    node = 5'd29;
          2'd1:    node = 5'd27;
          default: node = 5'd24;
        endcase
      UNIT_CU:
        case (idx)
          2'd0:    node = 5'd7;
          2'd1:    node = 5'd5;
          default: node = 5'd2;
        endcase
      UNIT_RU:
        case (idx)
          2'd0:    node = 5'd19;
          2'd1:    node = 5'd17;
          2'd2:    node = 5'd15;
          default: node = 5'd12;
        endcase
      default: node = HOME_NODE_DEF;
    endcase
    return node;
  endfunction

  // Graph node of each block pickup site.
  function automatic logic [4:0] blk_node(input logic [1:0] site);
    case (site)
      2'd0:    return 5'd22;
      2'd1:    return 5'd10;
      2'd2:    return 5'd23;
      default: return 5'd11;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-request round-robin arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   req[2:0]   : requests, bit 0 = EU, bit 1 = CU, bit 2 = RU
//   en         : arbitration enabled; pointer moves only when en and a grant is made
//   gnt[2:0]   : one-hot grant (all zero when en is low or nothing requests)
// The pointer holds the last granted requester; the search starts just after it.
// Reset points at RU so EU has first priority.
module rr_arbiter3 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  input  logic       en,
  output logic [2:0] gnt
);

  logic [1:0] ptr;

  always_comb begin
    gnt = 3'b000;
    if (en) begin
      case (ptr)
        2'd0: begin
          if (req[1])      gnt = 3'b010;
          else if (req[2]) gnt = 3'b100;
          else if (req[0]) gnt = 3'b001;
        end
        2'd1: begin
          if (req[2])      gnt = 3'b100;
          else if (req[0]) gnt = 3'b001;
          else if (req[1]) gnt = 3'b010;
        end
        default: begin
          if (req[0])      gnt = 3'b001;
          else if (req[1]) gnt = 3'b010;
          else if (req[2]) gnt = 3'b100;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 2'd2;
    end else if (|gnt) begin
      ptr <= gnt[0] ? 2'd0 : (gnt[1] ? 2'd1 : 2'd2);
    end
  end

endmodule

// File: rtl/fault_mission_scheduler.sv
// Fault-service mission scheduler for the EU, CU and RU sections.
// Keeps a saturating pending count per unit, picks a unit round-robin, and walks
// the path planner through scan legs, block pickup and rectify legs, then sends
// the bot home when nothing is pending.
//
// Ports:
//   clk_3125KHz, rst_n          : clock, asynchronous active-low reset
//   eu/cu/ru_fault_flag         : one-cycle new-fault pulses
//   block_valid, block_location : pickup site report (level)
//   curr_node                   : node the bot occupies
//   path_done                   : planner pulse, current leg finished
//   cpu_start                   : one-cycle pulse launching a leg
//   start_point, end_point      : leg source / target, registered with cpu_start
//   fault_location              : unit in service (0 none, 1 EU, 2 CU, 3 RU)
//   busy, all_done              : not IDLE/DONE, and in DONE
//   drop_count                  : saturating count of flags lost to full counters
//
// Planner handshake: cpu_start is high for one cycle with start_point/end_point
// valid from that same cycle and held until the next issue. The leg is finished
// by a path_done pulse seen while curr_node equals end_point; a path_done pulse
// with any other curr_node, or LEG_TIMEOUT cycles with no path_done, re-issues the
// same leg. path_done outside a leg state is ignored.
module fault_mission_scheduler
  import fault_sched_pkg::*;
#(
  parameter int         PEND_MAX    = 3,
  parameter int         LEG_TIMEOUT = 3125000,
  parameter logic [4:0] HOME_NODE   = HOME_NODE_DEF
) (
  input  logic       clk_3125KHz,
  input  logic       rst_n,
  input  logic       eu_fault_flag,
  input  logic       cu_fault_flag,
  input  logic       ru_fault_flag,
  input  logic       block_valid,
  input  logic [1:0] block_location,
  input  logic [4:0] curr_node,
  input  logic       path_done,
  output logic       cpu_start,
  output logic [4:0] start_point,
  output logic [4:0] end_point,
  output logic [1:0] fault_location,
  output logic       busy,
  output logic       all_done,
  output logic [7:0] drop_count
);

  localparam int            TW       = $clog2(LEG_TIMEOUT + 1);
  localparam logic [1:0]    PEND_SAT = 2'(PEND_MAX);
  localparam logic [TW-1:0] TMO_LAST = TW'(LEG_TIMEOUT - 1);

  state_t        state, state_nxt;
  logic [1:0]    unit_nxt;
  logic [1:0]    leg_idx, idx_nxt;
  logic          issue;
  logic [4:0]    target;
  logic [2:0]    dec;
  logic [2:0]    gnt;
  logic [2:0]    flags;
  logic [2:0]    drop;
  logic [2:0]    req;
  logic          arb_en;
  logic [1:0]    pend_cnt [3];
  logic [TW-1:0] tmo;
  logic          leg_wait, leg_ok, retry, last_wp, tmo_hit;
  logic [1:0]    gnt_unit;
  logic [1:0]    drop_n;
  logic [8:0]    drop_sum;

  assign flags    = {ru_fault_flag, cu_fault_flag, eu_fault_flag};
  assign req      = {pend_cnt[2] != 2'd0, pend_cnt[1] != 2'd0, pend_cnt[0] != 2'd0};
  assign leg_wait = state inside {S_SCAN, S_GO_BLK, S_RECTIFY, S_HOME};
  // tmo is 0 in the cpu_start cycle, so hitting LEG_TIMEOUT-1 re-issues exactly
  // LEG_TIMEOUT cycles after the previous issue.
  assign tmo_hit  = (tmo == TMO_LAST);
  assign leg_ok   = leg_wait && path_done && (curr_node == end_point);
  assign retry    = leg_wait && ((path_done && (curr_node != end_point)) ||
                                 (!path_done && tmo_hit));
  assign last_wp  = ({1'b0, leg_idx} == (wp_count(fault_location) - 3'd1));
  assign gnt_unit = gnt[0] ? UNIT_EU : (gnt[1] ? UNIT_CU : UNIT_RU);
  assign busy     = !((state == S_IDLE) || (state == S_DONE));
  assign all_done = (state == S_DONE);

  rr_arbiter3 u_arb (
    .clk   (clk_3125KHz),
    .rst_n (rst_n),
    .req   (req),
    .en    (arb_en),
    .gnt   (gnt)
  );

  always_comb begin
    state_nxt = state;
    unit_nxt  = fault_location;
    idx_nxt   = leg_idx;
    issue     = 1'b0;
    target    = end_point;
    dec       = 3'b000;
    arb_en    = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        arb_en = 1'b1;
        if (|gnt) begin
          state_nxt = S_SCAN;
          unit_nxt  = gnt_unit;
          idx_nxt   = 2'd0;
          issue     = 1'b1;
          target    = wp_node(gnt_unit, 2'd0);
        end else if (state == S_IDLE) begin
          if (curr_node != HOME_NODE) begin
            state_nxt = S_HOME;
            issue     = 1'b1;
            target    = HOME_NODE;
          end else begin
            state_nxt = S_DONE;
          end
        end
      end
      S_SCAN: begin
        if (leg_ok) begin
          if (last_wp) begin
            state_nxt = S_WAIT_BLK;
          end else begin
            idx_nxt = leg_idx + 2'd1;
            issue   = 1'b1;
            target  = wp_node(fault_location, leg_idx + 2'd1);
          end
        end else if (retry) begin
          issue = 1'b1;
        end
      end
      S_WAIT_BLK: begin
        if (block_valid) begin
          state_nxt = S_GO_BLK;
          issue     = 1'b1;
          target    = blk_node(block_location);
        end
      end
      S_GO_BLK: begin
        if (leg_ok) begin
          state_nxt = S_RECTIFY;
          idx_nxt   = 2'd0;
          issue     = 1'b1;
          target    = wp_node(fault_location, 2'd0);
        end else if (retry) begin
          issue = 1'b1;
        end
      end
      S_RECTIFY: begin
        if (leg_ok) begin
          if (last_wp) begin
            state_nxt = S_IDLE;
            unit_nxt  = UNIT_NONE;
            case (fault_location)
              UNIT_EU: dec = 3'b001;
              UNIT_CU: dec = 3'b010;
              UNIT_RU: dec = 3'b100;
              default: dec = 3'b000;
            endcase
          end else begin
            idx_nxt = leg_idx + 2'd1;
            issue   = 1'b1;
            target  = wp_node(fault_location, leg_idx + 2'd1);
          end
        end else if (retry) begin
          issue = 1'b1;
        end
      end
      S_HOME: begin
        if (leg_ok) begin
          state_nxt = S_IDLE;
        end else if (retry) begin
          issue = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_3125KHz or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      fault_location <= UNIT_NONE;
      leg_idx        <= 2'd0;
      cpu_start      <= 1'b0;
      start_point    <= 5'd0;
      end_point      <= 5'd0;
      tmo            <= '0;
    end else begin
      state          <= state_nxt;
      fault_location <= unit_nxt;
      leg_idx        <= idx_nxt;
      cpu_start      <= issue;
      if (issue) begin
        start_point <= curr_node;
        end_point   <= target;
        tmo         <= '0;
      end else if (leg_wait) begin
        tmo <= tmo + 1'b1;
      end else begin
        tmo <= '0;
      end
    end
  end

  // Per-unit pending counters. A flag and a completion for the same unit in one
  // cycle cancel, so that flag is never counted as dropped.
  for (genvar g = 0; g < 3; g++) begin : g_pend
    assign drop[g] = flags[g] && !dec[g] && (pend_cnt[g] == PEND_SAT);

    always_ff @(posedge clk_3125KHz or negedge rst_n) begin
      if (!rst_n) begin
        pend_cnt[g] <= 2'd0;
      end else if (flags[g] && !dec[g]) begin
        if (pend_cnt[g] != PEND_SAT) pend_cnt[g] <= pend_cnt[g] + 2'd1;
      end else if (dec[g] && !flags[g]) begin
        pend_cnt[g] <= pend_cnt[g] - 2'd1;
      end
    end
  end

  assign drop_n   = {1'b0, drop[0]} + {1'b0, drop[1]} + {1'b0, drop[2]};
  assign drop_sum = {1'b0, drop_count} + {7'd0, drop_n};

  always_ff @(posedge clk_3125KHz or negedge rst_n) begin
    if (!rst_n) begin
      drop_count <= 8'd0;
    end else begin
      drop_count <= (drop_sum > 9'd255) ? 8'd255 : drop_sum[7:0];
    end
  end

endmodule
